// File: rtl/apb_slave.sv
// apb_slave: APB completer in front of a 16 x 8-bit register file.
// Wait states come from a down-counter that is loaded on each setup cycle.
// Read data is captured at the end of SETUP. Writes commit on the completing edge.
module apb_slave #(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic       pclk,
  input  logic       rst_n,     // active-high asynchronous reset, despite the name
  input  logic [3:0] paddr,
  input  logic       pwrite,
  input  logic       psel,
  input  logic       penable,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic [7:0] prdata_q, prdata_d;
  logic [7:0] mem_q [16];
  logic [7:0] mem_d [16];

  logic setup_phase;
  logic access_phase;
  logic wr_en;

  // Bus phase decode straight from the requester's strobes.
  assign setup_phase  = psel & ~penable;
  assign access_phase = psel & penable;

  // pready is only raised for a transfer that began with a setup cycle seen
  // after reset. It drops combinationally the moment reset is asserted.
  assign pready = access_phase & (wait_q == 4'd0) & (state_q != IDLE) & ~rst_n;
  assign wr_en  = access_phase & pwrite & pready;

  assign prdata = prdata_q;

  // Next-state logic for the transfer-tracking FSM.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:    if (setup_phase) state_d = SETUP;
      SETUP:   state_d = psel ? ACCESS : IDLE;
      ACCESS: begin
        if (!psel)            state_d = IDLE;
        else if (setup_phase) state_d = SETUP;
        else                  state_d = ACCESS;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: wait counter, read capture and register-file write.
  always_comb begin
    wait_d   = wait_q;
    prdata_d = prdata_q;
    mem_d    = mem_q;
    if (setup_phase) begin
      wait_d = 4'(WAIT_STATES);
      if (!pwrite) prdata_d = mem_q[paddr];
    end else if (access_phase && wait_q != 4'd0) begin
      wait_d = wait_q - 4'd1;
    end
    if (wr_en) mem_d[paddr] = pwdata;
  end

  // All state updates on pclk. Reset clears everything, including the register file.
  always_ff @(posedge pclk or posedge rst_n) begin
    if (rst_n) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      prdata_q <= '0;
      // NOTE: the register file must read as zero after reset, so the storage is
      // built from resettable flops rather than a RAM macro.
      for (int i = 0; i < 16; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q  <= state_d;
      wait_q   <= wait_d;
      prdata_q <= prdata_d;
      for (int i = 0; i < 16; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_apb_slave.sv
// Testbench for apb_slave. Two instances are used: one with zero wait states
// and one with three. A behavioural requester drives them, and a per-instance
// register-file model supplies every expected value.
module tb_apb_slave;

  logic       pclk;
  logic       rst_n;
  logic [3:0] paddr;
  logic       pwrite;
  logic       psel0, psel3;
  logic       penable;
  logic [7:0] pwdata;
  logic [7:0] prdata0, prdata3;
  logic       pready0, pready3;

  int total = 0;
  int bad   = 0;

  // Reference model: register contents and the last read value, one set per instance.
  logic [7:0] model_mem [2][16];
  logic [7:0] exp_prd   [2];

  typedef struct {
    bit         wr;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs_a [8];
  vec_t vecs_b [4];

  apb_slave #(.WAIT_STATES(0)) dut_w0 (
    .pclk(pclk), .rst_n(rst_n), .paddr(paddr), .pwrite(pwrite), .psel(psel0),
    .penable(penable), .pwdata(pwdata), .prdata(prdata0), .pready(pready0)
  );

  apb_slave #(.WAIT_STATES(3)) dut_w3 (
    .pclk(pclk), .rst_n(rst_n), .paddr(paddr), .pwrite(pwrite), .psel(psel3),
    .penable(penable), .pwdata(pwdata), .prdata(prdata3), .pready(pready3)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic cur_pready(input int d);
    return (d == 1) ? pready3 : pready0;
  endfunction

  function automatic logic [7:0] cur_prdata(input int d);
    return (d == 1) ? prdata3 : prdata0;
  endfunction

  function automatic int ws(input int d);
    return (d == 1) ? 3 : 0;
  endfunction

  function automatic logic [7:0] dut_mem(input int d, input logic [3:0] a);
    return (d == 1) ? dut_w3.mem_q[a] : dut_w0.mem_q[a];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      exp_prd[d] = 8'h00;
      for (int i = 0; i < 16; i++) model_mem[d][i] = 8'h00;
    end
  endtask

  // Run one complete transfer, starting with a setup cycle on the next negedge.
  // The task returns during the completing cycle, so a following call runs back to back.
  task automatic do_xfer(input int d, input bit wr, input logic [3:0] a,
                         input logic [7:0] wd, output logic [7:0] rd);
    bit done;
    @(negedge pclk);
    paddr = a; pwrite = wr; pwdata = wd; penable = 1'b0;
    psel0 = (d == 0); psel3 = (d == 1);
    #1 check("setup_pready_low", cur_pready(d), 1'b0);
    if (!wr) exp_prd[d] = model_mem[d][a];
    @(negedge pclk);
    penable = 1'b1;
    done = 1'b0;
    for (int k = 0; k <= 20 && !done; k++) begin
      #1;
      check("access_prdata", cur_prdata(d), exp_prd[d]);
      if (wr) check("mem_not_yet_written", dut_mem(d, a), model_mem[d][a]);
      if (cur_pready(d)) begin
        check("wait_cycles", k, ws(d));
        done = 1'b1;
      end else begin
        @(negedge pclk);
      end
    end
    if (!done) check("pready_timeout", 32'd0, 32'd1);
    if (wr) model_mem[d][a] = wd;
    rd = cur_prdata(d);
  endtask

  task automatic idle_cycle();
    @(negedge pclk);
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    #1;
    check("idle_pready0_low", pready0, 1'b0);
    check("idle_pready3_low", pready3, 1'b0);
  endtask

  task automatic run_table_a(input int d, input bit gap);
    logic [7:0] rd;
    for (int i = 0; i < 8; i++) begin
      do_xfer(d, vecs_a[i].wr, vecs_a[i].addr, vecs_a[i].data, rd);
      if (!vecs_a[i].wr) check(gap ? "tableA_gap_read" : "tableA_b2b_read", rd, vecs_a[i].exp);
      if (gap) idle_cycle();
    end
    if (!gap) idle_cycle();
  endtask

  initial begin
    logic [7:0] rd;

    vecs_a[0] = '{1'b1, 4'd2, 8'd5,  8'd0};
    vecs_a[1] = '{1'b1, 4'd3, 8'd10, 8'd0};
    vecs_a[2] = '{1'b1, 4'd4, 8'd5,  8'd0};
    vecs_a[3] = '{1'b1, 4'd5, 8'd10, 8'd0};
    vecs_a[4] = '{1'b0, 4'd1, 8'd0,  8'd0};
    vecs_a[5] = '{1'b0, 4'd2, 8'd0,  8'd5};
    vecs_a[6] = '{1'b0, 4'd3, 8'd0,  8'd10};
    vecs_a[7] = '{1'b0, 4'd4, 8'd0,  8'd5};

    vecs_b[0] = '{1'b1, 4'd0, 8'h12, 8'h00};
    vecs_b[1] = '{1'b0, 4'd0, 8'h00, 8'h12};
    vecs_b[2] = '{1'b1, 4'd0, 8'h34, 8'h00};
    vecs_b[3] = '{1'b0, 4'd0, 8'h00, 8'h34};

    // Reset with the bus idle.
    rst_n = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    paddr = '0; pwrite = 1'b0; pwdata = '0;
    model_reset();
    repeat (3) @(negedge pclk);
    check("reset_prdata0", prdata0, 8'h00);
    check("reset_pready0", pready0, 1'b0);
    check("reset_prdata3", prdata3, 8'h00);
    rst_n = 1'b0;
    @(negedge pclk);
    #1 check("post_reset_pready3", pready3, 1'b0);

    // Read all addresses after reset. Each read must see zero with a single ready cycle.
    for (int i = 0; i < 16; i++) begin
      do_xfer(0, 1'b0, 4'(i), 8'h00, rd);
      check("reset_read_zero", rd, 8'h00);
    end
    idle_cycle();

    // Table A: first back to back, then with an idle cycle between transfers.
    run_table_a(0, 1'b0);
    run_table_a(0, 1'b1);

    // Three wait states: write 15 <- 0xFF, then read it back.
    do_xfer(1, 1'b1, 4'd15, 8'hFF, rd);
    do_xfer(1, 1'b0, 4'd15, 8'h00, rd);
    check("ws3_read_back", rd, 8'hFF);
    idle_cycle();

    // Assert reset asynchronously during the access phase of write 7 <- 0xAA.
    @(negedge pclk);
    paddr = 4'd7; pwrite = 1'b1; pwdata = 8'hAA; psel0 = 1'b1; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    #1 check("pre_abort_pready", pready0, 1'b1);
    #2 rst_n = 1'b1;
    #1 check("abort_pready_drop", pready0, 1'b0);
    model_reset();
    @(negedge pclk);
    rst_n = 1'b0; psel0 = 1'b0; penable = 1'b0;
    do_xfer(0, 1'b0, 4'd7, 8'h00, rd);
    check("abort_no_write", rd, 8'h00);

    // Table B: alternate writes and reads to address 0, back to back.
    for (int i = 0; i < 4; i++) begin
      do_xfer(0, vecs_b[i].wr, vecs_b[i].addr, vecs_b[i].data, rd);
      if (!vecs_b[i].wr) check("tableB_read", rd, vecs_b[i].exp);
    end
    idle_cycle();

    // Random traffic to both instances. do_xfer checks every transfer against the model.
    for (int n = 0; n < 300; n++) begin
      int         d;
      bit         wr;
      logic [3:0] a;
      logic [7:0] wd;
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, 15));
      wd = 8'($urandom_range(0, 255));
      do_xfer(d, wr, a, wd, rd);
      if (!wr) check("rand_read", rd, model_mem[d][a]);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_slave.md
# apb_slave

APB (AMBA 3-style) completer providing a 16-entry × 8-bit read/write register file. It sits on the peripheral bus behind a single APB requester. It decodes 4-bit addresses, completes writes into the register file and returns read data on `prdata`. A parameterised number of wait states is inserted through `pready`.

## Interface
- `WAIT_STATES`, default 0: number of access-phase cycles with `pready` low before completion (0–15).
- `pclk` input 1: bus clock; all state changes on rising edge.
- `rst_n` input 1: asynchronous reset, active-high (asserted = 1), despite the legacy name.
- `paddr` input 4: register index 0–15.
- `pwrite` input 1: 1 = write, 0 = read.
- `psel` input 1: slave select.
- `penable` input 1: access-phase strobe.
- `pwdata` input 8: write data.
- `prdata` output 8: read data, registered.
- `pready` output 1: transfer completion, combinational from state.

## Operation
- Storage: `mem[0..15]`, 8 bits each. All entries are cleared to 0 on reset.
- FSM states:
  - IDLE: waiting for `psel`.
  - SETUP: `psel`=1, `penable`=0.
  - ACCESS: `psel`=1, `penable`=1.
- Transitions:
  - IDLE→SETUP when `psel`=1 and `penable`=0.
  - SETUP→ACCESS on the next edge.
  - ACCESS→IDLE on the completing edge if `psel` drops.
  - ACCESS→SETUP on the completing edge if `psel`=1 and `penable`=0, for a back-to-back transfer.
  - `psel`=0 in any state returns to IDLE.
- Wait counter:
  - Loaded with `WAIT_STATES` at the edge that enters ACCESS.
  - Decrements each ACCESS cycle while nonzero.
- `pready` = `psel` & `penable` & (counter == 0) & not in reset.
  - `WAIT_STATES`=0 gives zero-wait transfers.
- Write: `mem[paddr]` ← `pwdata` at the rising edge where `psel`&`penable`&`pwrite`&`pready`=1. Exactly one write per transfer.
- Read:
  - `prdata` ← `mem[paddr]` at the edge ending SETUP, i.e. `psel`=1, `penable`=0, `pwrite`=0.
  - `prdata` holds that value through ACCESS and after completion until the next read setup.
- Write transfers never modify `prdata`.
- Every 4-bit address is valid. There is no error response.
- `paddr`, `pwrite` and `pwdata` are assumed stable from SETUP through completion. If they change, the slave uses the value sampled at the relevant edge; it does not flag an error.

## Timing
- Reset values:
  - `prdata`=0, `pready`=0, FSM=IDLE, counter=0, all `mem`=0.
  - Reset takes effect immediately on assertion, independent of `pclk`.
- Reset mid-transfer aborts the transfer: no write is committed and `pready` is low. After release the slave waits in IDLE for a fresh SETUP.
- Zero-wait transfer (`WAIT_STATES`=0): 2 cycles.
  - Edge 1 ends SETUP; `prdata` is loaded for reads.
  - `pready`=1 throughout ACCESS.
  - Edge 2 completes the transfer; the write is committed.
- With N wait states, ACCESS lasts N+1 cycles. `pready` rises in the last one.
- Back-to-back transfers with no IDLE gap are supported.
- A read immediately following a write to the same address returns the new data. The write commits before the next SETUP edge samples `mem`.
- Read latency: data is valid on `prdata` from the cycle after the setup edge, which is before `pready` is sampled.

## Test plan
- Reset, then read addresses 0–15 → `prdata`=0 each; `pready` high exactly 1 ACCESS cycle per transfer.
- Back-to-back writes (2←5), (3←10), (4←5), (5←10), then reads of 1, 2, 3, 4 → 0, 5, 10, 5; `prdata` stable through each ACCESS phase.
- Same sequence with one IDLE cycle between transfers → identical read values; `pready`=0 while idle.
- `WAIT_STATES`=3: write 15←0xFF, then read 15 → `pready` low for 3 ACCESS cycles, then high; read returns 0xFF; the write commits only at the completing edge.
- Assert `rst_n`=1 asynchronously during the ACCESS phase of write 7←0xAA → `pready` drops immediately; after release, read 7 → 0x00.
- Write 0←0x12, read 0, write 0←0x34, read 0 back-to-back → 0x12 then 0x34; `prdata` unchanged by the write transfers in between.
